// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: pipelined RV32/RV64 branch resolver with valid/ready handshake and statistics
module branch_resolve_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned PIPE  = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [XLEN-1:0]  out_next_pc,
    output logic             out_misalign,
    output logic             out_illegal,
    output logic [CNT_W-1:0] taken_count,
    output logic [CNT_W-1:0] branch_count
);
    typedef struct packed {
        logic            taken;
        logic [XLEN-1:0] next_pc;
        logic            misalign;
        logic            illegal;
    } res_t;

    // funct3[2:1] picks the base condition, funct3[0] inverts it (NE/GE/GEU)
    function automatic res_t resolve(input logic eq, input logic lt, input logic ltu,
                                     input logic [2:0] f3, input logic [XLEN-1:0] target,
                                     input logic [XLEN-1:0] seq);
        res_t r;
        logic base;
        base       = f3[2] ? (f3[1] ? ltu : lt) : eq;
        r.illegal  = f3[2:1] == 2'b01;
        r.taken    = ~r.illegal & (base ^ f3[0]);
        r.next_pc  = r.taken ? target : seq;
        r.misalign = r.taken & (target[1:0] != 2'b00);
        return r;
    endfunction

    logic            in_eq, in_lt, in_ltu;
    logic [XLEN-1:0] in_target, in_seq;
    logic            out_adv, valid_d, out_valid_q;
    res_t            res_d, res_q;
    logic            consume;
    logic [CNT_W-1:0] taken_count_q, branch_count_q;

    assign in_eq     = rs1 == rs2;
    assign in_lt     = $signed(rs1) < $signed(rs2);
    assign in_ltu    = rs1 < rs2;
    assign in_target = pc + imm;
    assign in_seq    = pc + XLEN'(4);
    assign out_adv   = ~out_valid_q | out_ready;

    generate
        if (PIPE == 2) begin : g_pipe2
            logic            s1_valid_q, eq_q, lt_q, ltu_q;
            logic [2:0]      f3_q;
            logic [XLEN-1:0] target_q, seq_q;
            assign in_ready = ~flush & (~s1_valid_q | out_adv);
            assign valid_d  = s1_valid_q;
            assign res_d    = resolve(eq_q, lt_q, ltu_q, f3_q, target_q, seq_q);
            // stage 1: raw conditions and both candidate PCs
            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    s1_valid_q <= 1'b0;
                end else if (~s1_valid_q | out_adv) begin
                    s1_valid_q <= in_valid;
                    if (in_valid) begin
                        eq_q     <= in_eq;
                        lt_q     <= in_lt;
                        ltu_q    <= in_ltu;
                        f3_q     <= funct3;
                        target_q <= in_target;
                        seq_q    <= in_seq;
                    end
                end
            end
        end else begin : g_pipe1
            assign in_ready = ~flush & out_adv;
            assign valid_d  = in_valid & in_ready;
            assign res_d    = resolve(in_eq, in_lt, in_ltu, funct3, in_target, in_seq);
        end
    endgenerate

    // output stage: holds the selected result until the consumer takes it
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (out_adv) begin
            out_valid_q <= valid_d;
            if (valid_d) res_q <= res_d;
        end
    end

    assign consume = out_valid_q & out_ready & ~flush & ~res_q.illegal;

    // saturating statistics on consumed legal results
    always_ff @(posedge clk) begin
        if (reset) begin
            taken_count_q  <= '0;
            branch_count_q <= '0;
        end else if (consume) begin
            if (~&branch_count_q) branch_count_q <= branch_count_q + CNT_W'(1);
            if (res_q.taken && ~&taken_count_q) taken_count_q <= taken_count_q + CNT_W'(1);
        end
    end

    assign out_valid    = out_valid_q;
    assign out_taken    = res_q.taken;
    assign out_next_pc  = res_q.next_pc;
    assign out_misalign = res_q.misalign;
    assign out_illegal  = res_q.illegal;
    assign taken_count  = taken_count_q;
    assign branch_count = branch_count_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed checks of a PIPE=2/CNT_W=3 and a PIPE=1/CNT_W=16 resolver
module tb_branch_resolve_unit;
    logic        clk = 0, reset = 1, flush = 0;
    logic [2:0]  funct3 = 0;
    logic [31:0] rs1 = 0, rs2 = 0, pc = 0, imm = 0;
    logic        in_valid = 0, in_ready, out_valid, out_ready = 0, out_taken, out_misalign, out_illegal;
    logic [31:0] out_next_pc;
    logic [2:0]  taken_count, branch_count;
    logic        in_valid_b = 0, in_ready_b, out_valid_b, out_taken_b, out_misalign_b, out_illegal_b;
    logic [31:0] out_next_pc_b;
    logic [15:0] taken_count_b, branch_count_b;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(32), .PIPE(2), .CNT_W(3)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .pc(pc), .imm(imm), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_taken(out_taken), .out_next_pc(out_next_pc),
        .out_misalign(out_misalign), .out_illegal(out_illegal), .taken_count(taken_count),
        .branch_count(branch_count));

    branch_resolve_unit #(.XLEN(32), .PIPE(1), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .pc(pc), .imm(imm), .flush(flush), .out_valid(out_valid_b),
        .out_ready(1'b1), .out_taken(out_taken_b), .out_next_pc(out_next_pc_b),
        .out_misalign(out_misalign_b), .out_illegal(out_illegal_b), .taken_count(taken_count_b),
        .branch_count(branch_count_b));

    task automatic do_reset();
        @(negedge clk);
        reset = 1; flush = 0; in_valid = 0; in_valid_b = 0; out_ready = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 0;
    endtask

    task automatic run_a(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [31:0] i, output int lat,
                         output logic tk, output logic [31:0] npc, output logic mis, output logic ill);
        @(negedge clk);
        funct3 = f3; rs1 = a; rs2 = b; pc = p; imm = i; in_valid = 1; out_ready = 1;
        @(negedge clk);
        in_valid = 0; lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        tk = out_taken; npc = out_next_pc; mis = out_misalign; ill = out_illegal;
        @(negedge clk);
    endtask

    task automatic run_b(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [31:0] i, output int lat,
                         output logic tk, output logic [31:0] npc);
        @(negedge clk);
        funct3 = f3; rs1 = a; rs2 = b; pc = p; imm = i; in_valid_b = 1;
        @(negedge clk);
        in_valid_b = 0; lat = 1;
        while (!out_valid_b && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        tk = out_taken_b; npc = out_next_pc_b;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if ({out_valid, out_taken, out_misalign, out_illegal} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b exp 0000", {out_valid, out_taken, out_misalign, out_illegal}); end
        checks++; if (out_next_pc !== 32'h0) begin errors++; $display("FAIL reset_next_pc: got %h exp 0", out_next_pc); end
        checks++; if ({taken_count, branch_count} !== 6'b0) begin errors++; $display("FAIL reset_counts: got %h exp 0", {taken_count, branch_count}); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
        checks++; if ({out_valid_b, in_ready_b, taken_count_b, branch_count_b} !== {1'b0, 1'b1, 32'h0}) begin errors++; $display("FAIL reset_b: got %h", {out_valid_b, in_ready_b, taken_count_b, branch_count_b}); end
    endtask

    task automatic test_beq();
        int lat; logic tk, mis, ill; logic [31:0] npc;
        do_reset();
        run_a(3'b000, 5, 5, 32'h100, 32'h20, lat, tk, npc, mis, ill);
        checks++; if (lat !== 2) begin errors++; $display("FAIL beq_latency: got %0d exp 2", lat); end
        checks++; if (tk !== 1'b1 || npc !== 32'h120) begin errors++; $display("FAIL beq_result: got tk=%b pc=%h exp tk=1 pc=120", tk, npc); end
        checks++; if (branch_count !== 3'd1 || taken_count !== 3'd1) begin errors++; $display("FAIL beq_counts: got b=%0d t=%0d exp 1 1", branch_count, taken_count); end
    endtask

    task automatic test_signed();
        int lat; logic tk, mis, ill; logic [31:0] npc;
        do_reset();
        run_a(3'b100, 32'hFFFF_FFFF, 1, 32'h200, 32'h40, lat, tk, npc, mis, ill);
        checks++; if (tk !== 1'b1 || npc !== 32'h240) begin errors++; $display("FAIL blt_neg: got tk=%b pc=%h exp tk=1 pc=240", tk, npc); end
        run_a(3'b110, 32'hFFFF_FFFF, 1, 32'h200, 32'h40, lat, tk, npc, mis, ill);
        checks++; if (tk !== 1'b0 || npc !== 32'h204) begin errors++; $display("FAIL bltu_big: got tk=%b pc=%h exp tk=0 pc=204", tk, npc); end
        run_a(3'b101, 32'h8000_0000, 0, 32'h300, 32'h10, lat, tk, npc, mis, ill);
        checks++; if (tk !== 1'b0 || npc !== 32'h304) begin errors++; $display("FAIL bge_neg: got tk=%b pc=%h exp tk=0 pc=304", tk, npc); end
        run_a(3'b000, 7, 7, 32'hFFFF_FFF0, 32'h20, lat, tk, npc, mis, ill);
        checks++; if (tk !== 1'b1 || npc !== 32'h10) begin errors++; $display("FAIL wrap_target: got tk=%b pc=%h exp tk=1 pc=10", tk, npc); end
        run_a(3'b001, 7, 7, 32'hFFFF_FFFC, 32'h20, lat, tk, npc, mis, ill);
        checks++; if (tk !== 1'b0 || npc !== 32'h0) begin errors++; $display("FAIL wrap_seq: got tk=%b pc=%h exp tk=0 pc=0", tk, npc); end
        checks++; if (branch_count !== 3'd5 || taken_count !== 3'd2) begin errors++; $display("FAIL signed_counts: got b=%0d t=%0d exp 5 2", branch_count, taken_count); end
    endtask

    task automatic test_illegal_misalign();
        int lat; logic tk, mis, ill; logic [31:0] npc;
        do_reset();
        run_a(3'b010, 3, 3, 32'h400, 32'h8, lat, tk, npc, mis, ill);
        checks++; if ({ill, tk, mis} !== 3'b100 || npc !== 32'h404) begin errors++; $display("FAIL illegal_010: got ill/tk/mis=%b pc=%h exp 100 404", {ill, tk, mis}, npc); end
        run_a(3'b011, 3, 4, 32'h500, 32'h8, lat, tk, npc, mis, ill);
        checks++; if ({ill, tk, mis} !== 3'b100 || npc !== 32'h504) begin errors++; $display("FAIL illegal_011: got ill/tk/mis=%b pc=%h exp 100 504", {ill, tk, mis}, npc); end
        checks++; if (branch_count !== 3'd0 || taken_count !== 3'd0) begin errors++; $display("FAIL illegal_counts: got b=%0d t=%0d exp 0 0", branch_count, taken_count); end
        run_a(3'b001, 1, 2, 32'h100, 32'h2, lat, tk, npc, mis, ill);
        checks++; if ({ill, tk, mis} !== 3'b011 || npc !== 32'h102) begin errors++; $display("FAIL bne_misalign: got ill/tk/mis=%b pc=%h exp 011 102", {ill, tk, mis}, npc); end
        checks++; if (branch_count !== 3'd1 || taken_count !== 3'd1) begin errors++; $display("FAIL misalign_counts: got b=%0d t=%0d exp 1 1", branch_count, taken_count); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got[$];
        int k = 0;
        do_reset();
        funct3 = 3'b000; rs1 = 9; rs2 = 9; imm = 32'h100;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            out_ready = (c >= 5);
            in_valid = (k < 4);
            pc = 32'h1000 + 32'(k) * 32'h10;
            #1;
            if (c >= 2 && c <= 4) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready c=%0d: got %b exp 0", c, in_ready); end
                checks++; if (out_valid !== 1'b1 || out_next_pc !== 32'h1100) begin errors++; $display("FAIL stall_hold c=%0d: got v=%b pc=%h exp 1 1100", c, out_valid, out_next_pc); end
            end
            if (out_valid && out_ready) got.push_back(out_next_pc);
            if (in_valid && in_ready) k++;
        end
        in_valid = 0;
        checks++; if (got.size() !== 4) begin errors++; $display("FAIL stall_count: got %0d exp 4", got.size()); end
        for (int i = 0; i < got.size() && i < 4; i++) begin
            checks++; if (got[i] !== 32'h1100 + 32'(i) * 32'h10) begin errors++; $display("FAIL stall_order %0d: got %h exp %h", i, got[i], 32'h1100 + 32'(i) * 32'h10); end
        end
        checks++; if (branch_count !== 3'd4) begin errors++; $display("FAIL stall_branch_count: got %0d exp 4", branch_count); end
    endtask

    task automatic test_flush();
        do_reset();
        funct3 = 3'b000; rs1 = 1; rs2 = 1; imm = 32'h40;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            in_valid = 1; pc = 32'h2000 + 32'(c) * 32'h10;
        end
        @(negedge clk);
        pc = 32'h3000; flush = 1; out_ready = 1;
        #1;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL flush_cycle: got rdy=%b v=%b exp 0 1", in_ready, out_valid); end
        @(negedge clk);
        flush = 0; in_valid = 0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_after: got v=%b rdy=%b exp 0 1", out_valid, in_ready); end
        checks++; if (branch_count !== 3'd0 || taken_count !== 3'd0) begin errors++; $display("FAIL flush_counts: got b=%0d t=%0d exp 0 0", branch_count, taken_count); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || branch_count !== 3'd0) begin errors++; $display("FAIL flush_drain: got v=%b b=%0d exp 0 0", out_valid, branch_count); end
    endtask

    task automatic test_reset_midop();
        do_reset();
        @(negedge clk);
        funct3 = 3'b000; rs1 = 2; rs2 = 2; pc = 32'h40; imm = 32'h8; in_valid = 1; out_ready = 1;
        @(negedge clk);
        in_valid = 0; reset = 1; flush = 1;
        @(negedge clk);
        reset = 0; flush = 0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_next_pc !== 32'h0 || in_ready !== 1'b1) begin errors++; $display("FAIL midop_reset: got v=%b pc=%h rdy=%b exp 0 0 1", out_valid, out_next_pc, in_ready); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || branch_count !== 3'd0) begin errors++; $display("FAIL midop_drain: got v=%b b=%0d exp 0 0", out_valid, branch_count); end
    endtask

    task automatic test_saturate();
        int lat; logic tk, mis, ill; logic [31:0] npc;
        do_reset();
        run_a(3'b000, 1, 2, 32'h80, 32'h8, lat, tk, npc, mis, ill);
        checks++; if (branch_count !== 3'd1 || taken_count !== 3'd0) begin errors++; $display("FAIL nt_counts: got b=%0d t=%0d exp 1 0", branch_count, taken_count); end
        do_reset();
        for (int n = 1; n <= 9; n++) begin
            run_a(3'b111, 5, 3, 32'h80, 32'h8, lat, tk, npc, mis, ill);
            if (n == 6 || n == 9) begin
                checks++; if (branch_count !== (n == 6 ? 3'd6 : 3'd7) || taken_count !== (n == 6 ? 3'd6 : 3'd7)) begin errors++; $display("FAIL sat_counts n=%0d: got b=%0d t=%0d", n, branch_count, taken_count); end
            end
        end
    endtask

    task automatic test_pipe1();
        int lat; logic tk; logic [31:0] npc;
        do_reset();
        run_b(3'b000, 5, 5, 32'h100, 32'h20, lat, tk, npc);
        checks++; if (lat !== 1 || tk !== 1'b1 || npc !== 32'h120) begin errors++; $display("FAIL p1_beq: got lat=%0d tk=%b pc=%h exp 1 1 120", lat, tk, npc); end
        run_b(3'b101, 32'h8000_0000, 0, 32'h300, 32'h10, lat, tk, npc);
        checks++; if (tk !== 1'b0 || npc !== 32'h304) begin errors++; $display("FAIL p1_bge: got tk=%b pc=%h exp 0 304", tk, npc); end
        run_b(3'b110, 0, 1, 32'h300, 32'hFFFF_FFF0, lat, tk, npc);
        checks++; if (tk !== 1'b1 || npc !== 32'h2F0) begin errors++; $display("FAIL p1_bltu: got tk=%b pc=%h exp 1 2f0", tk, npc); end
        run_b(3'b011, 0, 1, 32'h300, 32'h10, lat, tk, npc);
        checks++; if (tk !== 1'b0 || npc !== 32'h304) begin errors++; $display("FAIL p1_illegal: got tk=%b pc=%h exp 0 304", tk, npc); end
        checks++; if (branch_count_b !== 16'd3 || taken_count_b !== 16'd2) begin errors++; $display("FAIL p1_counts: got b=%0d t=%0d exp 3 2", branch_count_b, taken_count_b); end
    endtask

    initial begin
        test_reset();
        test_beq();
        test_signed();
        test_illegal_misalign();
        test_back_to_back();
        test_flush();
        test_reset_midop();
        test_saturate();
        test_pipe1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
